// File: rtl/mem_bus_arbiter_if.sv
// Native memory-port bundle (picorv32 style valid/ready handshake).
// The master modport issues requests; the slave modport completes them.
interface mem_bus_arbiter_if;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output valid, instr, addr, wdata, wstrb,
    input  rdata, ready
  );

  modport slave (
    input  valid, instr, addr, wdata, wstrb,
    output rdata, ready
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for one native memory port, with grant held
// for the whole transaction and a watchdog that force-completes hung accesses.
module mem_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  mem_bus_arbiter_if.slave          m0,
  mem_bus_arbiter_if.slave          m1,
  mem_bus_arbiter_if.master         s,
  output logic [1:0]                grant,
  output logic                      timeout_err
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  logic busy;
  logic owner;
  logic timeout_hit;
  logic done;

  always_comb begin
    busy        = (state_q == BUSY0) || (state_q == BUSY1);
    owner       = (state_q == BUSY1);
    // A slave acknowledge in the final watchdog cycle wins over the timeout.
    timeout_hit = busy && !s.ready && (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);
    done        = busy && (s.ready || timeout_hit);
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wd_cnt_d     = wd_cnt_q;
    case (state_q)
      IDLE: begin
        wd_cnt_d = '0;
        if (m0.valid && (!m1.valid || last_grant_q)) begin
          state_d = BUSY0;
        end else if (m1.valid) begin
          state_d = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        if (done) begin
          state_d      = IDLE;
          last_grant_d = owner;
          wd_cnt_d     = '0;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = IDLE;
        wd_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wd_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  // Slave-side request is a pure mux of the owner's request, zero when idle.
  assign s.valid = busy;
  assign s.instr = busy && (owner ? m1.instr : m0.instr);
  assign s.addr  = busy ? (owner ? m1.addr  : m0.addr)  : 32'd0;
  assign s.wdata = busy ? (owner ? m1.wdata : m0.wdata) : 32'd0;
  assign s.wstrb = busy ? (owner ? m1.wstrb : m0.wstrb) : 4'd0;

  assign m0.ready = done && (state_q == BUSY0);
  assign m1.ready = done && (state_q == BUSY1);
  assign m0.rdata = timeout_hit ? TIMEOUT_RDATA : s.rdata;
  assign m1.rdata = timeout_hit ? TIMEOUT_RDATA : s.rdata;

  assign grant       = {state_q == BUSY1, state_q == BUSY0};
  assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single master, tie-break, round-robin,
// watchdog timeout, timeout/ready coincidence and mid-transaction reset.
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] grant;
  logic       timeout_err;
  int         n_assert = 0;
  int         n_fail = 0;

  mem_bus_arbiter_if m0_bus ();
  mem_bus_arbiter_if m1_bus ();
  mem_bus_arbiter_if s_bus ();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(64),
    .TIMEOUT_RDATA (32'hDEADBEEF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0         (m0_bus),
    .m1         (m1_bus),
    .s          (s_bus),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_svalid"}, 32'(s_bus.valid), 32'd0);
    check({tag, "_grant"},  32'(grant),       32'd0);
    check({tag, "_m0rdy"},  32'(m0_bus.ready), 32'd0);
    check({tag, "_m1rdy"},  32'(m1_bus.ready), 32'd0);
    check({tag, "_toerr"},  32'(timeout_err), 32'd0);
    check({tag, "_saddr"},  s_bus.addr,       32'd0);
  endtask

  initial begin
    logic early;
    m0_bus.valid = 0; m0_bus.instr = 0; m0_bus.addr = 0; m0_bus.wdata = 0; m0_bus.wstrb = 0;
    m1_bus.valid = 0; m1_bus.instr = 0; m1_bus.addr = 0; m1_bus.wdata = 0; m1_bus.wstrb = 0;
    s_bus.ready = 0; s_bus.rdata = 0;

    // Reset
    @(negedge clk); @(negedge clk); #1;
    check_idle("reset");
    resetn = 1'b1;

    // Single master read
    @(negedge clk);
    m0_bus.valid = 1; m0_bus.addr = 32'h0000_03FC; m0_bus.wstrb = 4'h0;
    #1 check("t1_idle_grant", 32'(grant), 32'd0);
    @(negedge clk); #1;
    check("t1_busy_svalid", 32'(s_bus.valid), 32'd1);
    check("t1_busy_grant",  32'(grant), 32'h1);
    check("t1_saddr",       s_bus.addr, 32'h0000_03FC);
    check("t1_no_rdy_yet",  32'(m0_bus.ready), 32'd0);
    @(negedge clk);
    s_bus.ready = 1; s_bus.rdata = 32'h0000_0005;
    #1;
    check("t1_svalid2", 32'(s_bus.valid), 32'd1);
    check("t1_m0rdy",   32'(m0_bus.ready), 32'd1);
    check("t1_m0rdata", m0_bus.rdata, 32'h0000_0005);
    check("t1_m1rdy",   32'(m1_bus.ready), 32'd0);
    @(negedge clk);
    m0_bus.valid = 0; s_bus.ready = 0;
    #1 check_idle("t1_after");

    // Simultaneous requests after reset: m0 wins, then m1 write
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m0_bus.valid = 1; m0_bus.addr = 32'h0000_0100; m0_bus.wstrb = 4'h0;
    m1_bus.valid = 1; m1_bus.addr = 32'h0000_0010; m1_bus.wdata = 32'hA5A5A5A5; m1_bus.wstrb = 4'hF;
    @(negedge clk); #1;
    check("t2_grant0", 32'(grant), 32'h1);
    check("t2_saddr0", s_bus.addr, 32'h0000_0100);
    s_bus.ready = 1; s_bus.rdata = 32'h0000_0011;
    #1;
    check("t2_m0rdy", 32'(m0_bus.ready), 32'd1);
    check("t2_m1rdy_hold", 32'(m1_bus.ready), 32'd0);
    @(negedge clk);
    m0_bus.valid = 0; s_bus.ready = 0;
    #1 check("t2_gap_grant", 32'(grant), 32'd0);
    @(negedge clk); #1;
    check("t2_grant1", 32'(grant), 32'h2);
    check("t2_saddr1", s_bus.addr, 32'h0000_0010);
    check("t2_swdata", s_bus.wdata, 32'hA5A5A5A5);
    check("t2_swstrb", 32'(s_bus.wstrb), 32'hF);
    s_bus.ready = 1;
    #1;
    check("t2_m1rdy", 32'(m1_bus.ready), 32'd1);
    check("t2_m0rdy_quiet", 32'(m0_bus.ready), 32'd0);
    @(negedge clk);
    m1_bus.valid = 0; m1_bus.wstrb = 0; m1_bus.wdata = 0; s_bus.ready = 0;
    #1 check("t2_end_grant", 32'(grant), 32'd0);

    // Round-robin under continuous load (last owner was m1, so m0 starts)
    m0_bus.valid = 1; m0_bus.addr = 32'h0000_0200;
    m1_bus.valid = 1; m1_bus.addr = 32'h0000_0300;
    for (int i = 0; i < 6; i++) begin
      #1 check($sformatf("rr%0d_idle", i), 32'(grant), 32'd0);
      @(negedge clk); #1;
      check($sformatf("rr%0d_grant", i), 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
      check($sformatf("rr%0d_saddr", i), s_bus.addr, (i % 2 == 0) ? 32'h200 : 32'h300);
      s_bus.ready = 1;
      #1;
      check($sformatf("rr%0d_rdy", i), 32'({m1_bus.ready, m0_bus.ready}),
            (i % 2 == 0) ? 32'h1 : 32'h2);
      @(negedge clk);
      s_bus.ready = 0;
    end
    m0_bus.valid = 0; m1_bus.valid = 0;

    // Watchdog timeout on m1 (last owner m1, only m1 requests)
    @(negedge clk);
    m1_bus.valid = 1; m1_bus.addr = 32'h0000_2000; s_bus.rdata = 32'h1111_1111;
    early = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk); #1;
      if (c == 1) check("to_grant", 32'(grant), 32'h2);
      if (c < 64) early = early | m1_bus.ready | timeout_err;
    end
    check("to_no_early", 32'(early), 32'd0);
    check("to_m1rdy",  32'(m1_bus.ready), 32'd1);
    check("to_m1rdata", m1_bus.rdata, 32'hDEADBEEF);
    check("to_err",    32'(timeout_err), 32'd1);
    check("to_m0rdy",  32'(m0_bus.ready), 32'd0);
    @(negedge clk);
    m1_bus.valid = 0;
    #1;
    check("to_err_pulse", 32'(timeout_err), 32'd0);
    check("to_after_grant", 32'(grant), 32'd0);
    m0_bus.valid = 1; m0_bus.addr = 32'h0000_0004;
    @(negedge clk); #1;
    check("to_next_grant", 32'(grant), 32'h1);
    s_bus.ready = 1; s_bus.rdata = 32'h0000_1234;
    #1;
    check("to_next_rdy",   32'(m0_bus.ready), 32'd1);
    check("to_next_rdata", m0_bus.rdata, 32'h0000_1234);
    check("to_next_err",   32'(timeout_err), 32'd0);
    @(negedge clk);
    m0_bus.valid = 0; s_bus.ready = 0;

    // s_ready on exactly the 64th busy cycle: normal completion
    @(negedge clk);
    m0_bus.valid = 1; m0_bus.addr = 32'h0000_3000;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (c == 64) begin
        s_bus.ready = 1; s_bus.rdata = 32'h0BAD_F00D;
      end
      #1;
    end
    check("edge_m0rdy",  32'(m0_bus.ready), 32'd1);
    check("edge_rdata",  m0_bus.rdata, 32'h0BAD_F00D);
    check("edge_no_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    m0_bus.valid = 0; s_bus.ready = 0;

    // Reset mid-transaction, then a late s_ready pulse while idle
    @(negedge clk);
    m0_bus.valid = 1; m0_bus.addr = 32'h0000_0040;
    @(negedge clk); #1;
    check("rst_busy_grant", 32'(grant), 32'h1);
    resetn = 1'b0; m0_bus.valid = 0;
    @(negedge clk);
    resetn = 1'b1; s_bus.ready = 1; s_bus.rdata = 32'h0000_0099;
    #1 check_idle("rst_late_ready");
    @(negedge clk);
    s_bus.ready = 0;
    m0_bus.valid = 1; m0_bus.addr = 32'h0000_0044;
    @(negedge clk); #1;
    check("rst_next_grant", 32'(grant), 32'h1);
    check("rst_next_saddr", s_bus.addr, 32'h0000_0044);
    s_bus.ready = 1; s_bus.rdata = 32'h0000_0077;
    #1;
    check("rst_next_rdy",   32'(m0_bus.ready), 32'd1);
    check("rst_next_rdata", m0_bus.rdata, 32'h0000_0077);
    @(negedge clk);
    m0_bus.valid = 0; s_bus.ready = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
